mem_sync_bank: RTL and testbench

- Parametrised, clocked successor to the combinational 16-bit word memory.
- Single-port synchronous RAM: DEPTH words of DW bits, per-byte write enables, 1-cycle registered read.
- Read data is presented as upper and lower halves (dou/dol).
- Built-in clear sequencer zeroes the array after reset or on request. The block sits behind the datapath's load/store unit.

---
 rtl/mem_sync_bank_if.sv | 53 +++++
 rtl/mem_sync_bank.sv | 193 +++++++++++++++++++
 tb/tb_mem_sync_bank.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_sync_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_sync_bank_if
// Description : Request/response bundle for mem_sync_bank.
//               master : load/store side (drives req/we/be/addr/di/clr)
//               slave  : memory bank (drives rdy/busy/dov/dou/dol)
//               Ports  : req, we, be[NB], addr[AW], di[DW], clr  (master->slave)
//                        rdy, busy, dov, dou[DW/2], dol[DW/2]   (slave->master)
//               With MEM_SYNC_BANK_PARITY_EN defined, also carries
//               perr[NB] (slave->master) and perr_inj[NB] (master->slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_sync_bank_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  localparam int c_NB = DW / 8;

  logic            req;
  logic            we;
  logic [c_NB-1:0] be;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   di;
  logic            clr;
  logic            rdy;
  logic            busy;
  logic            dov;
  logic [DW/2-1:0] dou;
  logic [DW/2-1:0] dol;
`ifdef MEM_SYNC_BANK_PARITY_EN
  logic [c_NB-1:0] perr;
  logic [c_NB-1:0] perr_inj;
`endif

  modport master (
    output req, we, be, addr, di, clr,
`ifdef MEM_SYNC_BANK_PARITY_EN
    output perr_inj,
    input  perr,
`endif
    input  rdy, busy, dov, dou, dol
  );

  modport slave (
    input  req, we, be, addr, di, clr,
`ifdef MEM_SYNC_BANK_PARITY_EN
    input  perr_inj,
    output perr,
`endif
    output rdy, busy, dov, dou, dol
  );
endinterface
`default_nettype wire

// File: rtl/mem_sync_bank.sv
`default_nettype none
// ============================================================================
// Module      : mem_sync_bank
// Description : Single-port synchronous RAM, 2**AW words of DW bits, per-byte
//               write enables, registered read presented as upper/lower
//               halves. A clear sequencer zeroes the array one word per cycle
//               after reset or on a clr pulse.
//               Ports : clk, rst_n (async, active low), bus (slave modport:
//                       req/we/be/addr/di/clr in, rdy/busy/dov/dou/dol out).
//               Optional feature macro: MEM_SYNC_BANK_PARITY_EN
//                 stores one even-parity bit per byte lane and reports lane
//                 mismatches on bus.perr alongside dov; bus.perr_inj flips the
//                 stored parity of written lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_sync_bank #(
  parameter int DW = 16,
  parameter int AW = 16,
  parameter int WT = 1
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  mem_sync_bank_if.slave bus
);
  localparam int c_NB    = DW / 8;
  localparam int c_HW    = DW / 2;
  localparam int c_DEPTH = 2 ** AW;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW-1:0]     r_ptr;
  logic [AW-1:0]     w_ptr_nxt;

  logic [DW-1:0]     r_mem [c_DEPTH];

  logic              w_accept;
  logic              w_wr_acc;
  logic              w_ret;
  logic              w_clearing;
  logic              w_mem_we;
  logic [AW-1:0]     w_mem_addr;
  logic [DW-1:0]     w_mem_wdata;
  logic [DW-1:0]     w_old;
  logic [DW-1:0]     w_merged;
  logic [DW-1:0]     w_rd_word;

  logic              r_ret;
  logic [AW-1:0]     r_raddr;
  logic              r_dov;
  logic [DW-1:0]     r_dout;

  // ---------------------------------------------------------------------------
  // Request acceptance: clr in IDLE wins over a simultaneous req.
  // ---------------------------------------------------------------------------
  assign w_clearing = (r_state == ST_CLEAR);
  assign w_accept   = (r_state == ST_IDLE) && bus.req && !bus.clr;
  assign w_wr_acc   = w_accept && bus.we;
  // A write only produces read data when write-through is enabled.
  assign w_ret      = w_accept && (!bus.we || (WT != 0));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_CLEAR: begin
        // ptr wraps back to 0 after the last word, so the next sweep starts clean.
        w_ptr_nxt = r_ptr + 1'b1;
        if (&r_ptr) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (bus.clr) begin
          w_state_nxt = ST_CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Byte-lane merge of the write data into the currently stored word.
  // ---------------------------------------------------------------------------
  assign w_old     = r_mem[bus.addr];
  assign w_rd_word = r_mem[r_raddr];

`ifdef MEM_SYNC_BANK_PARITY_EN
  logic [c_NB-1:0] r_par [c_DEPTH];
  logic [c_NB-1:0] w_old_par;
  logic [c_NB-1:0] w_par_new;
  logic [c_NB-1:0] w_rd_par;
  logic [c_NB-1:0] r_perr;

  assign w_old_par = r_par[bus.addr];
`endif

  for (genvar gi = 0; gi < c_NB; gi++) begin : g_lane
    assign w_merged[8*gi +: 8] = bus.be[gi] ? bus.di[8*gi +: 8] : w_old[8*gi +: 8];
`ifdef MEM_SYNC_BANK_PARITY_EN
    // Even parity: stored bit makes the lane plus its parity bit even.
    assign w_par_new[gi] = bus.be[gi] ? ((^bus.di[8*gi +: 8]) ^ bus.perr_inj[gi])
                                      : w_old_par[gi];
    assign w_rd_par[gi]  = ^w_rd_word[8*gi +: 8];
`endif
  end

  // ---------------------------------------------------------------------------
  // Array write port, shared between the clear sweep and accepted writes.
  // ---------------------------------------------------------------------------
  assign w_mem_we    = w_clearing || w_wr_acc;
  assign w_mem_addr  = w_clearing ? r_ptr : bus.addr;
  assign w_mem_wdata = w_clearing ? '0 : w_merged;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

`ifdef MEM_SYNC_BANK_PARITY_EN
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_par[w_mem_addr] <= w_clearing ? '0 : w_par_new;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Read pipeline. The address is captured at acceptance and the array is
  // sampled one edge later, so a write-through returns the merged word and a
  // read right behind a write to the same address sees the new data.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ret   <= 1'b0;
      r_raddr <= '0;
      r_dov   <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_ret <= w_ret;
      if (w_accept) begin
        r_raddr <= bus.addr;
      end
      r_dov <= r_ret;
      // dou/dol hold their last value when nothing is returned.
      if (r_ret) begin
        r_dout <= w_rd_word;
      end
    end
  end

`ifdef MEM_SYNC_BANK_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perr <= '0;
    end else begin
      r_perr <= r_ret ? (w_rd_par ^ r_par[r_raddr]) : '0;
    end
  end

  assign bus.perr = r_perr;
`endif

  assign bus.rdy  = (r_state == ST_IDLE);
  assign bus.busy = (r_state == ST_CLEAR);
  assign bus.dov  = r_dov;
  assign bus.dou  = r_dout[DW-1:c_HW];
  assign bus.dol  = r_dout[c_HW-1:0];

endmodule
`default_nettype wire

// File: tb/tb_mem_sync_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_sync_bank
// Description : Self-checking bench for mem_sync_bank (DW=16, AW=4). A WT=1
//               instance is driven against a word/parity model with an
//               expected-response queue; a WT=0 instance gets a short
//               directed sequence.
//               Optional feature macro: MEM_SYNC_BANK_PARITY_EN
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_sync_bank;
  localparam int c_DW    = 16;
  localparam int c_AW    = 4;
  localparam int c_DEPTH = 16;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  perr;
    int          due;
  } exp_t;

  logic clk;
  logic rst_n;
  int   r_cyc;
  int   n_chk;
  int   n_pass;

  logic [15:0] mdl  [c_DEPTH];
  logic [1:0]  pinj [c_DEPTH];
  exp_t        q    [$];

  mem_sync_bank_if #(.DW(c_DW), .AW(c_AW)) bus ();
  mem_sync_bank_if #(.DW(c_DW), .AW(c_AW)) bus0 ();

  mem_sync_bank #(.DW(c_DW), .AW(c_AW), .WT(1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  mem_sync_bank #(.DW(c_DW), .AW(c_AW), .WT(0)) u_dut_wt0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) r_cyc <= r_cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < c_DEPTH; i++) begin
      mdl[i]  = 16'h0000;
      pinj[i] = 2'b00;
    end
  endtask

  // One access on the WT=1 instance; returns 1 ns after the accepting edge.
  task automatic acc(input logic w, input logic [1:0] b, input logic [3:0] a,
                     input logic [15:0] d, input logic [1:0] inj);
    exp_t e;
    bus.req  = 1'b1;
    bus.we   = w;
    bus.be   = b;
    bus.addr = a;
    bus.di   = d;
`ifdef MEM_SYNC_BANK_PARITY_EN
    bus.perr_inj = inj;
`endif
    @(posedge clk);
    #1;
    if (w) begin
      for (int i = 0; i < 2; i++) begin
        if (b[i]) begin
          mdl[a][8*i +: 8] = d[8*i +: 8];
          pinj[a][i]       = inj[i];
        end
      end
    end
    e.data = mdl[a];
    e.perr = pinj[a];
    e.due  = r_cyc + 1;
    q.push_back(e);
    bus.req = 1'b0;
    bus.we  = 1'b0;
`ifdef MEM_SYNC_BANK_PARITY_EN
    bus.perr_inj = 2'b00;
`endif
  endtask

  task automatic acc0(input logic w, input logic [3:0] a, input logic [15:0] d);
    bus0.req  = 1'b1;
    bus0.we   = w;
    bus0.be   = 2'b11;
    bus0.addr = a;
    bus0.di   = d;
    @(posedge clk);
    #1;
    bus0.req = 1'b0;
    bus0.we  = 1'b0;
  endtask

  // Counts negedges with busy=1 until rdy returns; bounded.
  task automatic count_busy(input string tag);
    int n;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.busy) n = n + 1;
      else break;
    end
    chk(tag, n, 16);
    chk({tag, "_rdy"}, bus.rdy, 1'b1);
  endtask

  // Response monitor for the WT=1 instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.dov) begin
        if (q.size() == 0) begin
          chk("dov_unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          chk("rd_data", {bus.dou, bus.dol}, e.data);
          chk("rd_latency", r_cyc, e.due);
`ifdef MEM_SYNC_BANK_PARITY_EN
          chk("rd_perr", bus.perr, e.perr);
`endif
        end
      end else if (q.size() > 0 && q[0].due <= r_cyc) begin
        chk("dov_missing", 0, 1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    r_cyc  = 0;
    rst_n  = 1'b0;
    bus.req = 1'b0; bus.we = 1'b0; bus.be = '0; bus.addr = '0; bus.di = '0; bus.clr = 1'b0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.be = '0; bus0.addr = '0; bus0.di = '0; bus0.clr = 1'b0;
`ifdef MEM_SYNC_BANK_PARITY_EN
    bus.perr_inj  = 2'b00;
    bus0.perr_inj = 2'b00;
`endif
    model_clear();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 1'b1);
    chk("rst_rdy", bus.rdy, 1'b0);
    chk("rst_dov", bus.dov, 1'b0);
    chk("rst_dout", {bus.dou, bus.dol}, 16'h0000);
`ifdef MEM_SYNC_BANK_PARITY_EN
    chk("rst_perr", bus.perr, 2'b00);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    count_busy("init_busy");

    // WT=0 instance: writes give no dov and leave dou/dol alone
    chk("wt0_rdy", bus0.rdy, 1'b1);
    acc0(1'b1, 4'd1, 16'h1357);
    acc0(1'b0, 4'd1, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    chk("wt0_rd1_dov", bus0.dov, 1'b1);
    chk("wt0_rd1", {bus0.dou, bus0.dol}, 16'h1357);
    acc0(1'b1, 4'd2, 16'hBEEF);
    @(negedge clk);
    chk("wt0_wr_dov_a", bus0.dov, 1'b0);
    @(negedge clk);
    chk("wt0_wr_dov_b", bus0.dov, 1'b0);
    chk("wt0_wr_hold", {bus0.dou, bus0.dol}, 16'h1357);
    acc0(1'b0, 4'd2, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    chk("wt0_rd2_dov", bus0.dov, 1'b1);
    chk("wt0_rd2", {bus0.dou, bus0.dol}, 16'hBEEF);

    // Cleared contents
    acc(1'b0, 2'b00, 4'd0, 16'h0, 2'b00);
    acc(1'b0, 2'b00, 4'd7, 16'h0, 2'b00);
    acc(1'b0, 2'b00, 4'd15, 16'h0, 2'b00);

    // Full write, write-through, then read
    acc(1'b1, 2'b11, 4'd3, 16'hA55A, 2'b00);
    acc(1'b0, 2'b00, 4'd3, 16'h0, 2'b00);

    // Byte-lane merges
    acc(1'b1, 2'b11, 4'd5, 16'h1234, 2'b00);
    acc(1'b1, 2'b10, 4'd5, 16'hFFFF, 2'b00);
    acc(1'b0, 2'b00, 4'd5, 16'h0, 2'b00);
    acc(1'b1, 2'b00, 4'd5, 16'h0000, 2'b00);
    acc(1'b0, 2'b00, 4'd5, 16'h0, 2'b00);
    acc(1'b1, 2'b01, 4'd15, 16'hC3C3, 2'b00);

    // Back-to-back write then read of the same address, and a random burst
    acc(1'b1, 2'b11, 4'd8, 16'hCAFE, 2'b00);
    acc(1'b0, 2'b00, 4'd8, 16'h0, 2'b00);
    for (int i = 0; i < 12; i++) begin
      acc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
          16'($urandom), 2'b00);
    end
    bus.addr = 4'd3;

`ifdef MEM_SYNC_BANK_PARITY_EN
    acc(1'b1, 2'b11, 4'd6, 16'h00FF, 2'b01);
    acc(1'b0, 2'b00, 4'd6, 16'h0, 2'b00);
    acc(1'b1, 2'b01, 4'd6, 16'h0011, 2'b00);
    acc(1'b0, 2'b00, 4'd6, 16'h0, 2'b00);
`endif

    // Reset in the middle of a read burst
    acc(1'b1, 2'b11, 4'd3, 16'hA55A, 2'b00);
    acc(1'b0, 2'b00, 4'd3, 16'h0, 2'b00);
    acc(1'b0, 2'b00, 4'd8, 16'h0, 2'b00);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dov", bus.dov, 1'b0);
    chk("mid_rst_dout", {bus.dou, bus.dol}, 16'h0000);
    chk("mid_rst_busy", bus.busy, 1'b1);
    chk("mid_rst_rdy", bus.rdy, 1'b0);
    q.delete();
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    count_busy("rerst_busy");
    acc(1'b0, 2'b00, 4'd3, 16'h0, 2'b00);
    acc(1'b0, 2'b00, 4'd8, 16'h0, 2'b00);

    // Put data back, then clr with a colliding write
    acc(1'b1, 2'b11, 4'd4, 16'h7777, 2'b00);
    acc(1'b1, 2'b11, 4'd9, 16'h9999, 2'b00);
    bus.clr  = 1'b1;
    bus.req  = 1'b1;
    bus.we   = 1'b1;
    bus.be   = 2'b11;
    bus.addr = 4'd4;
    bus.di   = 16'h1111;
    @(negedge clk);
    chk("clr_rdy", bus.rdy, 1'b1);
    @(posedge clk);
    #1;
    bus.clr = 1'b0;
    bus.req = 1'b0;
    bus.we  = 1'b0;
    model_clear();
    count_busy("clr_busy");
    acc(1'b0, 2'b00, 4'd4, 16'h0, 2'b00);
    acc(1'b0, 2'b00, 4'd9, 16'h0, 2'b00);
    acc(1'b0, 2'b00, 4'd0, 16'h0, 2'b00);
    acc(1'b0, 2'b00, 4'd15, 16'h0, 2'b00);

    repeat (4) @(negedge clk);
    chk("sb_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
